sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Single-clock FIFO, parametrised in data width and depth; next-generation
//   general-purpose buffer for the design's byte/word streams. Adds: full use
//   of all DEPTH entries, occupancy count, programmable almost-full/almost-empty,
//   read-through-while-full, sticky overflow/underflow error flags, and an
//   optional first-word-fall-through (FWFT) read mode.
// PARAMETERS
//   DATA_W    8         data width, bits (>=1)
//   DEPTH     32        entries; power of 2, >=4
//   AF_THRESH DEPTH-4   almost_full asserted when count >= AF_THRESH
//   AE_THRESH 4         almost_empty asserted when count <= AE_THRESH
//   FWFT      0         0 = registered read (1-cycle latency); 1 = fall-through
// PORTS
//   clk          in   1                 clock, all logic on rising edge
//   rst          in   1                 synchronous reset, active-high
//   wr_en        in   1                 write request
//   wr_data      in   DATA_W            write data
//   rd_en        in   1                 read request (FWFT: pop/acknowledge)
//   rd_data      out  DATA_W            read data
//   rd_valid     out  1                 rd_data holds a valid popped/head word
//   full         out  1                 count == DEPTH
//   empty        out  1                 count == 0
//   almost_full  out  1                 count >= AF_THRESH
//   almost_empty out  1                 count <= AE_THRESH
//   count        out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   overflow     out  1                 sticky: write dropped
//   underflow    out  1                 sticky: read of empty FIFO
//   clr_err      in   1                 clears overflow/underflow next edge
// BEHAVIOUR
//   - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0,
//     overflow=underflow=0; empty=1, almost_empty=1, full=almost_full=0.
//     Storage not cleared. Reset mid-operation discards all content; rst wins
//     over every other input in that cycle.
//   - Pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally; occupancy held in
//     count register (no pointer-difference ambiguity); all DEPTH entries usable.
//   - rd_acc = rd_en & ~empty. wr_acc = wr_en & (~full | rd_acc): write when full
//     accepted if a read is accepted in the same cycle.
//   - count next = count + wr_acc - rd_acc; simultaneous accepted rd+wr: unchanged.
//   - Empty with wr_en & rd_en: write accepted, read rejected, underflow set;
//     new word not bypassed to output.
//   - Flags full/empty/almost_* decoded from registered count; valid the cycle
//     after the edge that changes count.
//   - overflow set when wr_en & ~wr_acc; underflow set when rd_en & empty.
//     Sticky until clr_err=1 (cleared next edge) or rst; a set event in the same
//     cycle as clr_err keeps the flag set.
//   - FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid=1 the following
//     cycle (1-cycle pulse per accepted read); otherwise rd_valid=0, rd_data holds.
//   - FWFT=1: rd_data = mem[rd_ptr] combinationally, rd_valid = ~empty; rd_acc
//     advances rd_ptr; next head visible after the edge. Data written to empty
//     FIFO appears on rd_data one cycle after the write edge.
//   - Data order strictly first-in first-out across wrap-around.
// TESTING
//   1. rst, then 32 writes 0x00..0x1F (DEPTH=32) -> count=32, full=1 after last;
//      33rd wr_en -> data dropped, overflow=1, count stays 32.
//   2. From full, wr_en+rd_en together with 0xAA -> read returns 0x00, count=32,
//      overflow unchanged; after draining, 0xAA is the last word out.
//   3. Write/read 100 words 0..99 with random gaps -> outputs 0..99 in order
//      across pointer wrap; FWFT=0 rd_valid pulses exactly once per read.
//   4. count 27->28 -> almost_full rises; count 5->4 -> almost_empty rises;
//      rd_en on empty -> underflow=1, clr_err=1 -> underflow=0 next cycle.
//   5. FWFT=1: write 0x5C to empty -> next cycle rd_valid=1, rd_data=0x5C with no
//      rd_en; rd_en -> empty=1, rd_valid=0 after edge.
//   6. rst asserted with 10 entries and wr_en=rd_en=1 -> next cycle count=0,
//      empty=1, rd_valid=0, rd_data=0, error flags 0.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read/status bundle for sync_fifo_param
// The producer/consumer side drives through master; the FIFO itself uses slave.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy count, sticky errors, optional FWFT
// Occupancy lives in its own register so all DEPTH entries are usable without pointer ambiguity.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   fifo
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_w;
    logic              empty_w;
    logic              rd_acc;
    logic              wr_acc;

    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    always_comb begin
        empty_w = (count_q == '0);
        full_w  = (count_q == DEPTH_C);
        rd_acc  = fifo.rd_en & ~empty_w;
        wr_acc  = fifo.wr_en & (~full_w | rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr] <= fifo.wr_data;
    end

    // A new error event wins over clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (fifo.wr_en & ~wr_acc) | (overflow_q & ~fifo.clr_err);
            underflow_q <= (fifo.rd_en & empty_w) | (underflow_q & ~fifo.clr_err);
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr];
                end
            end

            assign fifo.rd_data  = rd_data_q;
            assign fifo.rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head word is shown directly; zeroed while empty so stale storage never leaks out.
            assign fifo.rd_data  = empty_w ? '0 : mem[rd_ptr];
            assign fifo.rd_valid = ~empty_w;
        end
    endgenerate

    assign fifo.full         = full_w;
    assign fifo.empty        = empty_w;
    assign fifo.almost_full  = (count_q >= AF_C);
    assign fifo.almost_empty = (count_q <= AE_C);
    assign fifo.count        = count_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param (registered and FWFT instances)
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) f0 ();
    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) f1 ();

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(DEPTH-4), .AE_THRESH(4), .FWFT(0)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .fifo (f0.slave)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(DEPTH-4), .AE_THRESH(4), .FWFT(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .fifo (f1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int m0 = 0;
    int m1 = 0;
    int pulses0 = 0;
    logic [DW-1:0] last0 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step0(input logic rs, input logic wr, input logic [DW-1:0] d,
                         input logic rd, input logic clr);
        logic racc, wacc;
        rst = rs; f0.wr_en = wr; f0.wr_data = d; f0.rd_en = rd; f0.clr_err = clr;
        if (rs) begin
            q0.delete(); m0 = 0; q1.delete(); m1 = 0;
        end else begin
            racc = rd && (m0 != 0);
            wacc = wr && ((m0 != DEPTH) || racc);
            if (wacc) q0.push_back(d);
            m0 = m0 + int'(wacc) - int'(racc);
        end
        @(posedge clk); #1;
    endtask

    task automatic step1(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic racc, wacc;
        rst = 1'b0; f1.wr_en = wr; f1.wr_data = d; f1.rd_en = rd; f1.clr_err = 1'b0;
        racc = rd && (m1 != 0);
        wacc = wr && ((m1 != DEPTH) || racc);
        if (wacc) q1.push_back(d);
        m1 = m1 + int'(wacc) - int'(racc);
        @(posedge clk); #1;
    endtask

    // Registered-mode monitor: every rd_valid pulse must carry the oldest outstanding word.
    always @(negedge clk) begin
        if (f0.rd_valid === 1'b1) begin
            pulses0++;
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd0_unexpected: got 0x%0h, expected no output", f0.rd_data);
            end else begin
                chk("rd0_data", 32'(f0.rd_data), 32'(q0.pop_front()));
                last0 = f0.rd_data;
            end
        end
    end

    // FWFT monitor: compares the head word at the moment it is acknowledged.
    always @(negedge clk) begin
        if (f1.rd_valid === 1'b1 && f1.rd_en === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd1_unexpected: got 0x%0h, expected no output", f1.rd_data);
            end else begin
                chk("rd1_data", 32'(f1.rd_data), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, cyc, p_start;
        rst = 1'b1;
        f0.wr_en = 0; f0.wr_data = '0; f0.rd_en = 0; f0.clr_err = 0;
        f1.wr_en = 0; f1.wr_data = '0; f1.rd_en = 0; f1.clr_err = 0;
        step0(1, 0, 8'h00, 0, 0);
        step0(1, 0, 8'h00, 0, 0);
        step0(0, 0, 8'h00, 0, 0);

        chk("rst_count", 32'(f0.count), 0);
        chk("rst_empty", 32'(f0.empty), 1);
        chk("rst_almost_empty", 32'(f0.almost_empty), 1);
        chk("rst_full", 32'(f0.full), 0);
        chk("rst_almost_full", 32'(f0.almost_full), 0);
        chk("rst_rd_valid", 32'(f0.rd_valid), 0);
        chk("rst_rd_data", 32'(f0.rd_data), 0);
        chk("rst_overflow", 32'(f0.overflow), 0);
        chk("rst_underflow", 32'(f0.underflow), 0);

        // Fill completely, then one write too many
        for (int i = 0; i < DEPTH; i++) step0(0, 1, 8'(i), 0, 0);
        chk("t1_count_full", 32'(f0.count), 32);
        chk("t1_full", 32'(f0.full), 1);
        chk("t1_almost_full", 32'(f0.almost_full), 1);
        chk("t1_overflow_clear", 32'(f0.overflow), 0);
        step0(0, 1, 8'hEE, 0, 0);
        chk("t1_overflow", 32'(f0.overflow), 1);
        chk("t1_count_stays", 32'(f0.count), 32);

        // Read-through while full
        step0(0, 1, 8'hAA, 1, 0);
        chk("t2_count", 32'(f0.count), 32);
        chk("t2_overflow_kept", 32'(f0.overflow), 1);
        chk("t2_full", 32'(f0.full), 1);
        for (int i = 0; i < DEPTH; i++) step0(0, 0, 8'h00, 1, 0);
        step0(0, 0, 8'h00, 0, 0);
        chk("t2_last_word", 32'(last0), 32'h0AA);
        chk("t2_empty", 32'(f0.empty), 1);
        chk("t2_sb_drained", 32'(q0.size()), 0);
        step0(0, 0, 8'h00, 0, 1);
        chk("t2_overflow_cleared", 32'(f0.overflow), 0);

        // 100 words with random gaps across several pointer wraps
        p_start = pulses0; sent = 0; cyc = 0;
        while ((sent < 100 || m0 > 0) && cyc < 3000) begin
            logic w, r;
            w = (sent < 100) && (m0 < DEPTH) && ($urandom_range(0, 2) != 0);
            r = (m0 > 0) && ($urandom_range(0, 1) == 1);
            step0(0, w, 8'(sent), r, 0);
            if (w) sent++;
            cyc++;
        end
        chk("t3_budget", 32'(cyc < 3000), 1);
        step0(0, 0, 8'h00, 0, 0);
        chk("t3_pulses", 32'(pulses0 - p_start), 100);
        chk("t3_last", 32'(last0), 99);
        chk("t3_empty", 32'(f0.empty), 1);
        chk("t3_no_errors", 32'({f0.overflow, f0.underflow}), 0);

        // Threshold edges and error flag handling
        for (int i = 0; i < 5; i++) step0(0, 1, 8'(8'h40 + i), 0, 0);
        chk("t4_count5", 32'(f0.count), 5);
        chk("t4_ae_at5", 32'(f0.almost_empty), 0);
        step0(0, 0, 8'h00, 1, 0);
        chk("t4_ae_at4", 32'(f0.almost_empty), 1);
        for (int i = 0; i < 23; i++) step0(0, 1, 8'(8'h50 + i), 0, 0);
        chk("t4_count27", 32'(f0.count), 27);
        chk("t4_af_at27", 32'(f0.almost_full), 0);
        step0(0, 1, 8'h67, 0, 0);
        chk("t4_af_at28", 32'(f0.almost_full), 1);
        chk("t4_full_at28", 32'(f0.full), 0);
        for (int i = 0; i < 28; i++) step0(0, 0, 8'h00, 1, 0);
        step0(0, 0, 8'h00, 0, 0);
        chk("t4_drained", 32'(f0.empty), 1);
        step0(0, 0, 8'h00, 1, 0);
        chk("t4_underflow", 32'(f0.underflow), 1);
        step0(0, 0, 8'h00, 1, 1);
        chk("t4_set_beats_clear", 32'(f0.underflow), 1);
        step0(0, 0, 8'h00, 0, 1);
        chk("t4_underflow_cleared", 32'(f0.underflow), 0);
        step0(0, 1, 8'h77, 1, 0);
        chk("t4_empty_rdwr_count", 32'(f0.count), 1);
        chk("t4_empty_rdwr_underflow", 32'(f0.underflow), 1);
        chk("t4_no_bypass", 32'(f0.rd_valid), 0);
        step0(0, 0, 8'h00, 1, 1);
        step0(0, 0, 8'h00, 0, 0);
        chk("t4_bypass_word_out", 32'(last0), 32'h077);

        // Reset mid-operation with requests asserted
        step0(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) step0(0, 1, 8'(8'h90 + i), 0, 0);
        chk("t6_count10", 32'(f0.count), 10);
        step0(1, 1, 8'hFF, 1, 0);
        chk("t6_count", 32'(f0.count), 0);
        chk("t6_empty", 32'(f0.empty), 1);
        chk("t6_rd_valid", 32'(f0.rd_valid), 0);
        chk("t6_rd_data", 32'(f0.rd_data), 0);
        chk("t6_errors", 32'({f0.overflow, f0.underflow}), 0);
        step0(0, 0, 8'h00, 0, 0);

        // First-word-fall-through instance
        chk("t5_rd_valid_empty", 32'(f1.rd_valid), 0);
        step1(1, 8'h5C, 0);
        chk("t5_fwft_valid", 32'(f1.rd_valid), 1);
        chk("t5_fwft_data", 32'(f1.rd_data), 32'h05C);
        step1(0, 8'h00, 1);
        chk("t5_empty_after_pop", 32'(f1.empty), 1);
        chk("t5_valid_after_pop", 32'(f1.rd_valid), 0);
        step1(1, 8'h11, 0);
        step1(1, 8'h22, 0);
        step1(1, 8'h33, 0);
        step1(0, 8'h00, 1);
        chk("t5_next_head", 32'(f1.rd_data), 32'h022);
        step1(0, 8'h00, 1);
        step1(0, 8'h00, 1);
        chk("t5_drained", 32'(f1.empty), 1);
        chk("t5_sb_drained", 32'(q1.size()), 0);
        step1(0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
